// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: state encoding, register map and TIMING field layout for lcd_bus_ctrl
package lcd_bus_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_DONE} state_e;
   localparam logic [1:0] ADDR_CMD    = 2'd0;
   localparam logic [1:0] ADDR_DWR    = 2'd1;
   localparam logic [1:0] ADDR_DRD    = 2'd2;
   localparam logic [1:0] ADDR_TIMING = 2'd3;
   localparam int TIM_S_OFF   = 0;
   localparam int TIM_P_OFF   = 4;
   localparam int TIM_H_OFF   = 8;
   localparam int TIM_FIELD_W = 4;
endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable down-counter; tc flags the last cycle of a phase
module lcd_phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign tc = cnt_q == '0;
   always_comb cnt_d = load ? load_val : (tc ? cnt_q : cnt_q - 1'b1);
   always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: Avalon-MM slave sequencing an 8080-style parallel LCD bus
// Define LCD_READ_EN to include the bus-read path (lcd_rd_n strobe and read capture).
module lcd_bus_ctrl
   import lcd_bus_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int CNT_W     = 4,
   parameter int SETUP_DEF = 1,
   parameter int PULSE_DEF = 2,
   parameter int HOLD_DEF  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic              read_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              waitrequest,
   output logic              lcd_cs_n,
   output logic              lcd_rs,
   output logic              lcd_wr_n,
   output logic              lcd_rd_n,
   output logic [DATA_W-1:0] lcd_data_out,
   output logic              lcd_data_oe,
   input  logic [DATA_W-1:0] lcd_data_in
);
   state_e state_q, state_d;
   logic [CNT_W-1:0] s_q, s_d, p_q, p_d, h_q, h_d, p_sh_q, p_sh_d, h_sh_q, h_sh_d, ld_val;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic wr_op_q, wr_op_d, rs_q, rs_d, cs_n_q, cs_n_d, wr_n_q, wr_n_d, oe_q, oe_d;
   logic req_wr, req_rd, tim_wr, start, ld, tc, busy_d;
   logic [31:0] tim_rd, bus_rd;
   logic unused;

   function automatic logic [CNT_W-1:0] strobe_ld(input logic [CNT_W-1:0] p);
      return p == '0 ? '0 : p - 1'b1;
   endfunction

   assign req_wr      = chipselect & ~write_n & (address == ADDR_CMD | address == ADDR_DWR);
   assign tim_wr      = chipselect & ~write_n & address == ADDR_TIMING;
   assign start       = state_q == ST_IDLE & (req_wr | req_rd);
   assign waitrequest = ~reset & (req_wr | req_rd) & state_q != ST_DONE;
   assign unused      = ^{writedata, lcd_data_in, read_n};

   lcd_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk(clk), .reset(reset), .load(ld), .load_val(ld_val), .tc(tc)
   );

`ifdef LCD_READ_EN
   logic rd_n_q, rd_n_d;
   logic [DATA_W-1:0] cap_q, cap_d;
   assign req_rd   = chipselect & write_n & ~read_n & address == ADDR_DRD;
   assign lcd_rd_n = rd_n_q;
   assign bus_rd   = (state_q == ST_DONE & ~wr_op_q) ? 32'(cap_q) : '0;
   always_comb begin
      rd_n_d = ~(state_d == ST_STROBE & ~wr_op_d);
      cap_d  = (state_q == ST_STROBE & tc & ~wr_op_q) ? lcd_data_in : cap_q;
   end
   always_ff @(posedge clk) begin
      rd_n_q <= reset ? 1'b1 : rd_n_d;
      cap_q  <= reset ? '0 : cap_d;
   end
`else
   assign req_rd   = 1'b0;
   assign lcd_rd_n = 1'b1;
   assign bus_rd   = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         s_q     <= CNT_W'(SETUP_DEF);
         p_q     <= CNT_W'(PULSE_DEF);
         h_q     <= CNT_W'(HOLD_DEF);
         p_sh_q  <= '0;
         h_sh_q  <= '0;
         dout_q  <= '0;
         wr_op_q <= 1'b0;
         rs_q    <= 1'b0;
         cs_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         p_q     <= p_d;
         h_q     <= h_d;
         p_sh_q  <= p_sh_d;
         h_sh_q  <= h_sh_d;
         dout_q  <= dout_d;
         wr_op_q <= wr_op_d;
         rs_q    <= rs_d;
         cs_n_q  <= cs_n_d;
         wr_n_q  <= wr_n_d;
         oe_q    <= oe_d;
      end
   end

   // The timer is loaded with (phase length - 1) on every phase entry
   always_comb begin
      state_d = state_q;
      ld      = 1'b0;
      ld_val  = '0;
      unique case (state_q)
         ST_IDLE: if (start) begin
            state_d = s_q == '0 ? ST_STROBE : ST_SETUP;
            ld      = 1'b1;
            ld_val  = s_q == '0 ? strobe_ld(p_q) : s_q - 1'b1;
         end
         ST_SETUP: if (tc) begin
            state_d = ST_STROBE;
            ld      = 1'b1;
            ld_val  = strobe_ld(p_sh_q);
         end
         ST_STROBE: if (tc) begin
            state_d = h_sh_q == '0 ? ST_DONE : ST_HOLD;
            ld      = 1'b1;
            ld_val  = h_sh_q - 1'b1;
         end
         ST_HOLD: if (tc) state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_d     = tim_wr ? CNT_W'(writedata[TIM_S_OFF +: TIM_FIELD_W]) : s_q;
      p_d     = tim_wr ? CNT_W'(writedata[TIM_P_OFF +: TIM_FIELD_W]) : p_q;
      h_d     = tim_wr ? CNT_W'(writedata[TIM_H_OFF +: TIM_FIELD_W]) : h_q;
      p_sh_d  = start ? p_q : p_sh_q;
      h_sh_d  = start ? h_q : h_sh_q;
      wr_op_d = start ? req_wr : wr_op_q;
      rs_d    = start ? (req_wr ? address[0] : 1'b1) : rs_q;
      dout_d  = (start & req_wr) ? writedata[DATA_W-1:0] : dout_q;
      busy_d  = state_d inside {ST_SETUP, ST_STROBE, ST_HOLD};
      cs_n_d  = ~busy_d;
      wr_n_d  = ~(state_d == ST_STROBE & wr_op_d);
      oe_d    = busy_d & wr_op_d;
      tim_rd  = '0;
      tim_rd[31] = state_q != ST_IDLE;
      tim_rd[TIM_S_OFF +: CNT_W] = s_q;
      tim_rd[TIM_P_OFF +: CNT_W] = p_q;
      tim_rd[TIM_H_OFF +: CNT_W] = h_q;
      readdata = reset ? '0 : (chipselect & address == ADDR_TIMING) ? tim_rd : bus_rd;
   end

   assign lcd_cs_n     = cs_n_q;
   assign lcd_rs       = rs_q;
   assign lcd_wr_n     = wr_n_q;
   assign lcd_data_out = dout_q;
   assign lcd_data_oe  = oe_q;
endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb_lcd_bus_ctrl: directed self-checking bench for lcd_bus_ctrl
module tb_lcd_bus_ctrl;
   logic clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1, read_n = 1'b1;
   logic [1:0] address = '0;
   logic [31:0] writedata = '0, readdata;
   logic waitrequest, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_oe;
   logic [15:0] lcd_data_out, lcd_data_in = '0;
   int checks = 0, failures = 0;
   int r_done, r_cs, r_stb, r_oe, r_first, r_unst;
   logic r_rs;
   logic [15:0] r_dout;
   logic [31:0] r_rd;

   lcd_bus_ctrl dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
      .waitrequest(waitrequest), .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n),
      .lcd_rd_n(lcd_rd_n), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
      .lcd_data_in(lcd_data_in)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic do_xfer(input logic wr, input logic [1:0] addr, input logic [31:0] wd);
      chipselect = 1'b1; address = addr; writedata = wd; write_n = ~wr; read_n = wr;
      r_done = -1; r_cs = 0; r_stb = 0; r_oe = 0; r_first = -1; r_unst = 0;
      r_rs = 1'b0; r_dout = '0; r_rd = '0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (!lcd_cs_n) begin
            if (r_first < 0) begin r_first = c; r_rs = lcd_rs; r_dout = lcd_data_out; end
            if (lcd_rs !== r_rs || lcd_data_out !== r_dout) r_unst++;
            r_cs++;
         end
         if (wr ? !lcd_wr_n : !lcd_rd_n) r_stb++;
         if (lcd_data_oe) r_oe++;
         if (!waitrequest) begin r_done = c; r_rd = readdata; break; end
         @(posedge clk); #1;
      end
   endtask

   task automatic idle_bus;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; address = '0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({lcd_cs_n, lcd_wr_n, lcd_rd_n} !== 3'b111) begin failures++; $display("FAIL rst_strobes got=%b exp=111", {lcd_cs_n, lcd_wr_n, lcd_rd_n}); end
      checks++; if ({lcd_rs, lcd_data_oe, waitrequest} !== 3'b000) begin failures++; $display("FAIL rst_rs_oe_wait got=%b exp=000", {lcd_rs, lcd_data_oe, waitrequest}); end
      checks++; if (lcd_data_out !== 16'h0 || readdata !== 32'h0) begin failures++; $display("FAIL rst_data got=%h/%h exp=0/0", lcd_data_out, readdata); end
      reset = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b1; address = 2'd3; read_n = 1'b0;
      #1;
      checks++; if (readdata !== 32'h0000_0121) begin failures++; $display("FAIL rst_timing got=%h exp=00000121", readdata); end
      checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL rst_timing_wait got=%b exp=0", waitrequest); end
      idle_bus();
   endtask

   task automatic test_cmd_write;
      do_xfer(1'b1, 2'd0, 32'h0000_00AB);
      checks++; if (r_done !== 5) begin failures++; $display("FAIL cmd_done got=%0d exp=5", r_done); end
      checks++; if (r_first !== 1) begin failures++; $display("FAIL cmd_cs_fall got=%0d exp=1", r_first); end
      checks++; if (r_cs !== 4) begin failures++; $display("FAIL cmd_cs_len got=%0d exp=4", r_cs); end
      checks++; if (r_stb !== 2) begin failures++; $display("FAIL cmd_wr_len got=%0d exp=2", r_stb); end
      checks++; if (r_oe !== 4) begin failures++; $display("FAIL cmd_oe_len got=%0d exp=4", r_oe); end
      checks++; if (r_rs !== 1'b0 || r_dout !== 16'h00AB) begin failures++; $display("FAIL cmd_rs_data got=%b/%h exp=0/00ab", r_rs, r_dout); end
      checks++; if (r_unst !== 0) begin failures++; $display("FAIL cmd_stable got=%0d exp=0", r_unst); end
      idle_bus();
   endtask

   task automatic test_zero_timing;
      chipselect = 1'b1; address = 2'd3; write_n = 1'b0; writedata = 32'h0;
      #1;
      checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL tim_wr_wait got=%b exp=0", waitrequest); end
      idle_bus();
      do_xfer(1'b1, 2'd1, 32'h0000_1234);
      checks++; if (r_done !== 2) begin failures++; $display("FAIL zero_done got=%0d exp=2", r_done); end
      checks++; if (r_stb !== 1 || r_cs !== 1) begin failures++; $display("FAIL zero_lens got=%0d/%0d exp=1/1", r_stb, r_cs); end
      checks++; if (r_rs !== 1'b1 || r_dout !== 16'h1234) begin failures++; $display("FAIL zero_rs_data got=%b/%h exp=1/1234", r_rs, r_dout); end
      idle_bus();
      chipselect = 1'b1; address = 2'd3; write_n = 1'b0; writedata = 32'h121;
      idle_bus();
   endtask

   task automatic test_read;
      lcd_data_in = 16'h5A5A;
      do_xfer(1'b0, 2'd2, 32'h0);
`ifdef LCD_READ_EN
      checks++; if (r_done !== 5) begin failures++; $display("FAIL rd_done got=%0d exp=5", r_done); end
      checks++; if (r_stb !== 2 || r_cs !== 4) begin failures++; $display("FAIL rd_lens got=%0d/%0d exp=2/4", r_stb, r_cs); end
      checks++; if (r_oe !== 0) begin failures++; $display("FAIL rd_oe got=%0d exp=0", r_oe); end
      checks++; if (r_rd !== 32'h0000_5A5A) begin failures++; $display("FAIL rd_data got=%h exp=00005a5a", r_rd); end
      checks++; if (r_rs !== 1'b1) begin failures++; $display("FAIL rd_rs got=%b exp=1", r_rs); end
`else
      checks++; if (r_done !== 0 || r_cs !== 0) begin failures++; $display("FAIL rd_off got=%0d/%0d exp=0/0", r_done, r_cs); end
      checks++; if (r_rd !== 32'h0 || lcd_rd_n !== 1'b1) begin failures++; $display("FAIL rd_off_data got=%h/%b exp=0/1", r_rd, lcd_rd_n); end
`endif
      idle_bus();
   endtask

   task automatic test_timing_midxfer;
      int cs_cnt = 0;
      chipselect = 1'b1; address = 2'd0; writedata = 32'h55; write_n = 1'b0; read_n = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         #1;
         if (c == 2) begin
            address = 2'd3; writedata = 32'h333;
            #1;
            checks++; if (readdata !== 32'h8000_0121) begin failures++; $display("FAIL mid_busy_rd got=%h exp=80000121", readdata); end
            checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL mid_tim_wait got=%b exp=0", waitrequest); end
         end
         if (c == 3) begin
            address = 2'd0; writedata = 32'h55;
            #1;
            checks++; if (lcd_data_out !== 16'h0055 || waitrequest !== 1'b1) begin failures++; $display("FAIL mid_hold got=%h/%b exp=0055/1", lcd_data_out, waitrequest); end
         end
         if (!lcd_cs_n) cs_cnt++;
         if (c == 5) begin
            checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", waitrequest); end
         end
         if (c < 5) begin @(posedge clk); #1; end
      end
      checks++; if (cs_cnt !== 4) begin failures++; $display("FAIL mid_cs_len got=%0d exp=4", cs_cnt); end
      idle_bus();
      do_xfer(1'b1, 2'd0, 32'hC3);
      checks++; if (r_cs !== 9 || r_stb !== 3) begin failures++; $display("FAIL next_lens got=%0d/%0d exp=9/3", r_cs, r_stb); end
      checks++; if (r_done !== 10) begin failures++; $display("FAIL next_done got=%0d exp=10", r_done); end
      idle_bus();
   endtask

   task automatic test_reset_mid;
      chipselect = 1'b1; address = 2'd1; writedata = 32'h77; write_n = 1'b0; read_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (lcd_wr_n !== 1'b0) begin failures++; $display("FAIL rmid_strobe got=%b exp=0", lcd_wr_n); end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if ({lcd_cs_n, lcd_wr_n, waitrequest} !== 3'b110) begin failures++; $display("FAIL rmid_abort got=%b exp=110", {lcd_cs_n, lcd_wr_n, waitrequest}); end
      chipselect = 1'b0; write_n = 1'b1; reset = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b1; address = 2'd3; read_n = 1'b0;
      #1;
      checks++; if (readdata !== 32'h0000_0121) begin failures++; $display("FAIL rmid_timing got=%h exp=00000121", readdata); end
      idle_bus();
   endtask

   task automatic test_back_to_back;
      do_xfer(1'b1, 2'd1, 32'hA1);
      checks++; if (r_done !== 5) begin failures++; $display("FAIL b2b_first got=%0d exp=5", r_done); end
      @(posedge clk); #1;
      do_xfer(1'b1, 2'd1, 32'hB2);
      checks++; if (r_first !== 1 || r_done !== 5) begin failures++; $display("FAIL b2b_second got=%0d/%0d exp=1/5", r_first, r_done); end
      checks++; if (r_dout !== 16'h00B2) begin failures++; $display("FAIL b2b_data got=%h exp=00b2", r_dout); end
      idle_bus();
   endtask

   task automatic test_ignored;
      int cs_cnt = 0;
      chipselect = 1'b1; address = 2'd0; read_n = 1'b0; write_n = 1'b1;
      #1;
      checks++; if (waitrequest !== 1'b0 || readdata !== 32'h0) begin failures++; $display("FAIL ign_rd got=%b/%h exp=0/0", waitrequest, readdata); end
      for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (!lcd_cs_n) cs_cnt++; end
      read_n = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'hFFFF;
      #1;
      checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL ign_wr got=%b exp=0", waitrequest); end
      for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (!lcd_cs_n) cs_cnt++; end
      checks++; if (cs_cnt !== 0) begin failures++; $display("FAIL ign_cs got=%0d exp=0", cs_cnt); end
      idle_bus();
   endtask

   initial begin
      test_reset();
      test_cmd_write();
      test_zero_timing();
      test_read();
      test_timing_midxfer();
      test_reset_mid();
      test_back_to_back();
      test_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
